// File: rtl/serializer_arb.sv
// serializer_arb: round-robin arbiter sharing one word serializer between N_REQ sources.
// One word in flight at a time; illegal-mod words are consumed and dropped.
module serializer_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ARM_TMO = 3
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic [N_REQ*16-1:0] req_data_i,
  input  logic [N_REQ*4-1:0]  req_mod_i,
  input  logic [N_REQ-1:0]    req_val_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [15:0]         ser_data_o,
  output logic [3:0]          ser_mod_o,
  output logic                ser_val_o,
  input  logic                ser_busy_i,
  output logic [2:0]          grant_id_o,
  output logic                drop_o,
  output logic                tmo_o
);

  localparam int unsigned TW       = (ARM_TMO < 2) ? 1 : $clog2(ARM_TMO);
  localparam logic [TW-1:0] TMR_LAST = TW'(ARM_TMO - 1);
  localparam logic [2:0]    LAST_REQ = 3'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ARM, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [2:0]          ptr_q, ptr_next, winner;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [2*N_REQ-1:0]  rot;
  logic [3:0]          off, sum;
  logic                any_val, consume, legal;
  logic [15:0]         win_data;
  logic [3:0]          win_mod;

  // Rotate valids so bit i is requester (ptr+i) mod N_REQ; lowest set bit wins.
  always_comb begin
    rot     = {req_val_i, req_val_i} >> ptr_q;
    any_val = 1'b0;
    off     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any_val && rot[i]) begin
        any_val = 1'b1;
        off     = 4'(i);
      end
    end
    sum = {1'b0, ptr_q} + off;
    if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
    winner   = sum[2:0];
    win_data = '0;
    win_mod  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (winner == 3'(k)) begin
        win_data = req_data_i[16*k +: 16];
        win_mod  = req_mod_i[4*k +: 4];
      end
    end
  end

  assign consume  = (state_q == IDLE) && any_val && !ser_busy_i && !srst_i;
  assign legal    = (win_mod != 4'd1) && (win_mod != 4'd2);
  assign ptr_next = (winner == LAST_REQ) ? 3'd0 : winner + 3'd1;

  always_comb begin
    req_ready_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      req_ready_o[k] = consume && (winner == 3'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    tmo_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (consume && legal) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = ARM;
        tmr_d   = '0;
      end
      ARM: begin
        if (ser_busy_i) begin
          state_d = DRAIN;
        end else if (tmr_q == TMR_LAST) begin
          tmo_o   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DRAIN: begin
        if (!ser_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      tmr_q      <= '0;
      ser_data_o <= '0;
      ser_mod_o  <= '0;
      ser_val_o  <= 1'b0;
      grant_id_o <= '0;
      drop_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      ser_val_o <= consume && legal;
      drop_o    <= consume && !legal;
      if (consume) ptr_q <= ptr_next;
      if (consume && legal) begin
        ser_data_o <= win_data;
        ser_mod_o  <= win_mod;
        grant_id_o <= winner;
      end
    end
  end

endmodule

// File: tb/tb_serializer_arb.sv
// Self-checking bench for serializer_arb: vector table, directed corner sequences,
// a behavioural serializer, and randomized traffic against a transaction-level model.
module tb_serializer_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 3;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [63:0] req_data = '0;
  logic [15:0] req_mod = '0;
  logic [3:0]  req_val = '0;
  logic [3:0]  req_ready;
  logic [15:0] ser_data;
  logic [3:0]  ser_mod;
  logic        ser_val, ser_busy, grant_dummy;
  logic        busy_drv = 1'b0;
  logic        use_ser = 1'b0;
  logic [2:0]  grant_id;
  logic        drop, tmo;

  int checks = 0;
  int failures = 0;

  // behavioural serializer: shifts the low n bits of a word out MSB first, busy while shifting
  logic        sim_busy = 1'b0;
  logic [15:0] sim_sh = '0;
  int unsigned sim_left = 0;
  int unsigned sim_words = 0;
  int unsigned sim_overlap = 0;
  bit          stream_q[$];

  always #5 clk = ~clk;
  assign ser_busy = use_ser ? sim_busy : busy_drv;
  assign grant_dummy = 1'b0;

  serializer_arb #(.N_REQ(N), .ARM_TMO(TMO)) dut (
    .clk_i      (clk),
    .srst_i     (srst),
    .req_data_i (req_data),
    .req_mod_i  (req_mod),
    .req_val_i  (req_val),
    .req_ready_o(req_ready),
    .ser_data_o (ser_data),
    .ser_mod_o  (ser_mod),
    .ser_val_o  (ser_val),
    .ser_busy_i (ser_busy),
    .grant_id_o (grant_id),
    .drop_o     (drop),
    .tmo_o      (tmo)
  );

  always @(posedge clk) begin
    if (srst) begin
      sim_busy    <= 1'b0;
      sim_left    <= 0;
      sim_words   <= 0;
      sim_overlap <= 0;
      stream_q.delete();
    end else if (!use_ser) begin
      sim_busy <= 1'b0;
    end else if (sim_busy) begin
      stream_q.push_back(sim_sh[sim_left-1]);
      sim_left <= sim_left - 1;
      if (sim_left == 1) sim_busy <= 1'b0;
      if (ser_val) sim_overlap <= sim_overlap + 1;
    end else if (ser_val) begin
      sim_sh    <= ser_data;
      sim_left  <= (ser_mod == 4'd0) ? 16 : int'(ser_mod);
      sim_busy  <= 1'b1;
      sim_words <= sim_words + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    req_val = '0;
    busy_drv = 1'b0;
    tick();
    tick();
    srst = 1'b0;
  endtask

  task automatic set_word(input int unsigned k, input logic [15:0] d, input logic [3:0] m);
    req_data[16*k +: 16] = d;
    req_mod[4*k +: 4] = m;
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int i = 0; i < int'(N); i++) begin
      int k;
      k = (p + i) % int'(N);
      if (v[k]) return k;
    end
    return -1;
  endfunction

  typedef struct packed {
    logic [3:0]  val;
    logic [15:0] mods;
    logic        busy;
    logic [3:0]  e_ready;
    logic        e_sval;
    logic        e_drop;
  } vec_t;

  vec_t tbl [8];

  // model state for the randomized phase
  int          m_ptr, w, rise_n;
  bit          p_issue, w_rise, w_fall, free_m;
  logic        e_sval, e_drop, e_tmo;
  logic [15:0] e_data;
  logic [3:0]  e_mod, e_ready, mm;
  logic [2:0]  e_grant;
  int          got [5];
  int          n_got;
  logic [63:0] act_bits;
  logic [3:0]  hs;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0001, 16'h0000, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[1] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[2] = '{4'b1111, 16'h4444, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[3] = '{4'b0100, 16'h0200, 1'b0, 4'b0100, 1'b0, 1'b1};
    tbl[4] = '{4'b1000, 16'h1000, 1'b0, 4'b1000, 1'b0, 1'b1};
    tbl[5] = '{4'b1010, 16'hF0F0, 1'b0, 4'b0010, 1'b1, 1'b0};
    tbl[6] = '{4'b1100, 16'h0300, 1'b0, 4'b0100, 1'b1, 1'b0};
    tbl[7] = '{4'b0110, 16'h0010, 1'b0, 4'b0010, 1'b0, 1'b1};

    // reset state, with legal words offered throughout reset
    srst = 1'b1;
    req_val = 4'b1111;
    req_mod = 16'h4444;
    tick();
    settle();
    chk("rst_ready_during", req_ready, 4'b0000);
    tick();
    srst = 1'b0;
    req_val = '0;
    chk("rst_ser_val", ser_val, 1'b0);
    chk("rst_ser_data", ser_data, 16'h0);
    chk("rst_ser_mod", ser_mod, 4'h0);
    chk("rst_grant", grant_id, 3'd0);
    chk("rst_drop", drop, 1'b0);
    settle();
    chk("rst_tmo", tmo, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      req_mod = tbl[i].mods;
      req_data = {$urandom, $urandom};
      req_val = tbl[i].val;
      busy_drv = tbl[i].busy;
      settle();
      chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].e_ready);
      tick();
      chk($sformatf("vec%0d_sval", i), ser_val, tbl[i].e_sval);
      chk($sformatf("vec%0d_drop", i), drop, tbl[i].e_drop);
      req_val = '0;
      busy_drv = 1'b0;
    end

    // single word, full handshake with busy window, then timeout on the next word
    do_reset();
    set_word(0, 16'hA5F0, 4'd0);
    req_val = 4'b0001;
    settle();
    chk("t1_ready_T", req_ready, 4'b0001);
    tick();
    chk("t1_sval_T1", ser_val, 1'b1);
    chk("t1_data", ser_data, 16'hA5F0);
    chk("t1_mod", ser_mod, 4'd0);
    chk("t1_grant", grant_id, 3'd0);
    set_word(0, 16'h1234, 4'd9);
    settle();
    chk("t1_ready_issue", req_ready, 4'b0000);
    tick();
    chk("t1_sval_once", ser_val, 1'b0);
    busy_drv = 1'b1;
    settle();
    chk("t1_ready_arm", req_ready, 4'b0000);
    tick();
    settle();
    chk("t1_ready_drain", req_ready, 4'b0000);
    tick();
    chk("t1_no_reissue", ser_val, 1'b0);
    busy_drv = 1'b0;
    settle();
    chk("t1_ready_drain_fall", req_ready, 4'b0000);
    tick();
    settle();
    chk("t1_ready_next", req_ready, 4'b0001);
    tick();
    chk("t1_sval_2nd", ser_val, 1'b1);
    chk("t1_data_2nd", ser_data, 16'h1234);
    chk("t1_mod_2nd", ser_mod, 4'd9);
    req_val = '0;
    settle();
    chk("t4_tmo_issue", tmo, 1'b0);
    tick();
    settle();
    chk("t4_tmo_arm1", tmo, 1'b0);
    tick();
    settle();
    chk("t4_tmo_arm2", tmo, 1'b0);
    tick();
    settle();
    chk("t4_tmo_arm3", tmo, 1'b1);
    tick();
    settle();
    chk("t4_tmo_after", tmo, 1'b0);
    req_val = 4'b0001;
    settle();
    chk("t4_idle_again", req_ready, 4'b0001);
    req_val = '0;

    // drop followed by forward, with ptr moved to 2 by an earlier drop
    do_reset();
    set_word(1, 16'h1111, 4'd1);
    req_val = 4'b0010;
    settle();
    chk("t3_setup_ready", req_ready, 4'b0010);
    tick();
    chk("t3_setup_drop", drop, 1'b1);
    set_word(2, 16'h2222, 4'd2);
    set_word(3, 16'h3333, 4'd5);
    req_val = 4'b1100;
    settle();
    chk("t3_ready2", req_ready, 4'b0100);
    tick();
    chk("t3_drop", drop, 1'b1);
    chk("t3_no_sval", ser_val, 1'b0);
    req_val = 4'b1000;
    settle();
    chk("t3_ready3", req_ready, 4'b1000);
    tick();
    chk("t3_sval", ser_val, 1'b1);
    chk("t3_data", ser_data, 16'h3333);
    chk("t3_mod", ser_mod, 4'd5);
    chk("t3_grant", grant_id, 3'd3);
    chk("t3_drop_clear", drop, 1'b0);
    req_val = '0;

    // reset while draining
    do_reset();
    set_word(2, 16'hBEEF, 4'd7);
    req_val = 4'b0100;
    settle();
    chk("t5_ready", req_ready, 4'b0100);
    tick();
    req_val = '0;
    chk("t5_sval", ser_val, 1'b1);
    chk("t5_grant", grant_id, 3'd2);
    busy_drv = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) set_word(k, 16'h0F00 + 16'(k), 4'd4);
    srst = 1'b1;
    req_val = 4'b1111;
    settle();
    chk("t5_ready_in_rst", req_ready, 4'b0000);
    tick();
    srst = 1'b0;
    chk("t5_data0", ser_data, 16'h0);
    chk("t5_mod0", ser_mod, 4'h0);
    chk("t5_grant0", grant_id, 3'd0);
    chk("t5_sval0", ser_val, 1'b0);
    chk("t5_drop0", drop, 1'b0);
    settle();
    chk("t5_tmo0", tmo, 1'b0);
    chk("t5_ready_busy", req_ready, 4'b0000);
    tick();
    settle();
    chk("t5_ready_busy2", req_ready, 4'b0000);
    busy_drv = 1'b0;
    settle();
    chk("t5_ptr0", req_ready, 4'b0001);
    req_val = '0;

    // all requesters valid with a live serializer: rotation order
    do_reset();
    use_ser = 1'b1;
    for (int k = 0; k < 4; k++) set_word(k, 16'hC000 + 16'(k), 4'd4);
    req_val = 4'b1111;
    n_got = 0;
    for (int i = 0; i < 5; i++) got[i] = -1;
    for (int c = 0; c < 300 && n_got < 5; c++) begin
      tick();
      if (ser_val) begin
        got[n_got] = int'(grant_id);
        n_got++;
      end
    end
    req_val = '0;
    tick();
    chk("t2_count", 64'(n_got), 64'd5);
    chk("t2_g0", 64'(got[0]), 64'd0);
    chk("t2_g1", 64'(got[1]), 64'd1);
    chk("t2_g2", 64'(got[2]), 64'd2);
    chk("t2_g3", 64'(got[3]), 64'd3);
    chk("t2_g4", 64'(got[4]), 64'd0);
    chk("t2_words", 64'(sim_words), 64'd5);
    chk("t2_overlap", 64'(sim_overlap), 64'd0);

    // three words of different lengths through the serializer
    do_reset();
    set_word(0, 16'hC3A5, 4'd0);
    set_word(1, 16'h0005, 4'd3);
    set_word(2, 16'hD2B7, 4'd15);
    req_val = 4'b0111;
    for (int c = 0; c < 400; c++) begin
      if (req_val == 4'b0000 && sim_words >= 3 && !sim_busy && !ser_val) break;
      settle();
      hs = req_val & req_ready;
      tick();
      req_val = req_val & ~hs;
    end
    act_bits = '0;
    foreach (stream_q[i]) act_bits = {act_bits[62:0], stream_q[i]};
    chk("t6_nbits", 64'(stream_q.size()), 64'd34);
    chk("t6_stream", act_bits, {30'd0, 16'hC3A5, 3'b101, 15'h52B7});
    chk("t6_words", 64'(sim_words), 64'd3);
    chk("t6_overlap", 64'(sim_overlap), 64'd0);

    // randomized traffic against the model
    use_ser = 1'b0;
    do_reset();
    m_ptr = 0; p_issue = 0; w_rise = 0; w_fall = 0; rise_n = 0;
    e_sval = 0; e_drop = 0; e_data = '0; e_mod = '0; e_grant = '0;
    for (int c = 0; c < 800; c++) begin
      chk("rnd_sval", ser_val, e_sval);
      chk("rnd_drop", drop, e_drop);
      chk("rnd_data", ser_data, e_data);
      chk("rnd_mod", ser_mod, e_mod);
      chk("rnd_grant", grant_id, e_grant);
      srst = ($urandom_range(99) < 2);
      req_val = 4'($urandom);
      req_data = {$urandom, $urandom};
      req_mod = 16'($urandom);
      if ($urandom_range(99) < 30) busy_drv = ~busy_drv;
      settle();
      w = pick(req_val, m_ptr);
      free_m = !(p_issue || w_rise || w_fall);
      e_ready = (free_m && !srst && w >= 0 && !ser_busy) ? 4'(1 << w) : 4'b0000;
      e_tmo = w_rise && !ser_busy && (rise_n + 1 == int'(TMO));
      chk("rnd_ready", req_ready, e_ready);
      chk("rnd_tmo", tmo, e_tmo);
      if (srst) begin
        m_ptr = 0; p_issue = 0; w_rise = 0; w_fall = 0;
        e_sval = 0; e_drop = 0; e_data = '0; e_mod = '0; e_grant = '0;
      end else begin
        e_sval = 0;
        e_drop = 0;
        if (e_ready != 4'b0000) begin
          mm = req_mod[4*w +: 4];
          m_ptr = (w + 1) % int'(N);
          if (mm == 4'd1 || mm == 4'd2) begin
            e_drop = 1;
          end else begin
            e_sval = 1;
            e_data = req_data[16*w +: 16];
            e_mod = mm;
            e_grant = 3'(w);
            p_issue = 1;
          end
        end else if (p_issue) begin
          p_issue = 0;
          w_rise = 1;
          rise_n = 0;
        end else if (w_rise) begin
          if (ser_busy) begin
            w_rise = 0;
            w_fall = 1;
          end else if (e_tmo) begin
            w_rise = 0;
          end else begin
            rise_n++;
          end
        end else if (w_fall) begin
          if (!ser_busy) w_fall = 0;
        end
      end
      tick();
    end
    srst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
